// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad receive path (keypad_reader).
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

    localparam int KEY_W   = 4;
    localparam int FRAME_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_MULTI = 2'd2
    } key_state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Key count clipped to 0, 1 or "2 or more".
    function automatic logic [1:0] popcnt16(input logic [FRAME_W-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < FRAME_W; i++) begin
            n = n + {4'd0, v[i]};
        end
        return (n >= 5'd2) ? 2'd2 : n[1:0];
    endfunction

    // Bit position of the set key; only meaningful when exactly one bit is set.
    function automatic logic [KEY_W-1:0] bit_idx16(input logic [FRAME_W-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (v[i]) begin
                idx = KEY_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_frame_capture.sv
// Samples synchronized row lines against the column strobes and assembles
// one 16-bit frame per complete sweep, flagged by a one-cycle frame_done.
module keypad_frame_capture
    import keypad_pkg::*;
#(
    parameter int SETTLE = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [3:0]         i_col,
    input  logic [3:0]         i_row,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_frame_done
);

    localparam int CNT_W = $clog2(SETTLE + 2);

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [3:0]         r_col_prev;
    logic [3:0]         r_mask;
    logic [CNT_W-1:0]   r_stab_cnt;
    logic [FRAME_W-1:0] r_frame_buf;
    logic [FRAME_W-1:0] r_frame;
    logic               r_frame_done;

    logic               w_col_valid;
    logic [1:0]         w_col_idx;
    logic               w_sample;
    logic               w_complete;
    logic [FRAME_W-1:0] w_frame_merged;
    logic [3:0]         w_mask_merged;

    assign w_col_valid = is_onehot4(i_col);
    assign w_col_idx   = onehot_idx(i_col);
    // A strobe that changes on this very clock restarts settling, so never sample it.
    assign w_sample    = w_col_valid && (i_col == r_col_prev) &&
                         (r_stab_cnt == CNT_W'(SETTLE));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_frame_merged[4*gi +: 4] = (w_sample && (w_col_idx == 2'(gi))) ?
                                               r_row_sync : r_frame_buf[4*gi +: 4];
            assign w_mask_merged[gi] = r_mask[gi] | (w_sample && (w_col_idx == 2'(gi)));
        end
    endgenerate

    assign w_complete = w_sample && (w_col_idx == 2'd3) && (w_mask_merged == 4'hF);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_row_meta   <= '0;
            r_row_sync   <= '0;
            r_col_prev   <= '0;
            r_mask       <= '0;
            r_stab_cnt   <= '0;
            r_frame_buf  <= '0;
            r_frame      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_row_meta   <= i_row;
            r_row_sync   <= r_row_meta;
            r_col_prev   <= i_col;
            r_frame_done <= w_complete;

            if (i_col != r_col_prev) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != CNT_W'(SETTLE + 1)) begin
                r_stab_cnt <= r_stab_cnt + CNT_W'(1);
            end

            if (!w_col_valid) begin
                r_frame_buf <= '0;
                r_mask      <= '0;
            end else if (w_complete) begin
                r_frame_buf <= w_frame_merged;
                r_frame     <= w_frame_merged;
                r_mask      <= '0;
            end else begin
                r_frame_buf <= w_frame_merged;
                r_mask      <= w_mask_merged;
            end
        end
    end

    assign o_frame      = r_frame;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/keypad_reader.sv
// 4x4 keypad receive side: frame capture, frame debounce and single-key decode.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key is held.
module keypad_reader
    import keypad_pkg::*;
#(
    parameter int SETTLE   = 3,
    parameter int DEBOUNCE = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT   = 64
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_col,
    input  logic [3:0]       i_row,
    output logic [KEY_W-1:0] o_key_code,
    output logic             o_key_valid,
    output logic             o_key_held,
    output logic             o_multi
);

    localparam int MATCH_W = $clog2(DEBOUNCE + 1);

    logic [FRAME_W-1:0] w_frame;
    logic               w_frame_done;
    logic [MATCH_W-1:0] w_match_next;
    logic               w_accept;
    logic [1:0]         w_keys;
    logic [KEY_W-1:0]   w_code;

    key_state_t         r_state;
    logic [FRAME_W-1:0] r_prev_frame;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [KEY_W-1:0]   r_key_code;
    logic               r_key_valid;
    logic               r_key_held;
    logic               r_multi;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT + 1);
    logic [REP_W-1:0]   r_rep_cnt;
`endif

    keypad_frame_capture #(
        .SETTLE(SETTLE)
    ) u_capture (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_col        (i_col),
        .i_row        (i_row),
        .o_frame      (w_frame),
        .o_frame_done (w_frame_done)
    );

    always_comb begin
        w_match_next = MATCH_W'(1);
        if (w_frame == r_prev_frame) begin
            w_match_next = (r_match_cnt == MATCH_W'(DEBOUNCE)) ?
                           r_match_cnt : r_match_cnt + MATCH_W'(1);
        end
    end

    // The counter saturates, so every further identical frame is accepted again.
    assign w_accept = w_frame_done && (w_match_next == MATCH_W'(DEBOUNCE));
    assign w_keys   = popcnt16(w_frame);
    assign w_code   = bit_idx16(w_frame);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_prev_frame <= '0;
            r_match_cnt  <= '0;
            r_key_code   <= '0;
            r_key_valid  <= 1'b0;
            r_key_held   <= 1'b0;
            r_multi      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt    <= '0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_done) begin
                r_prev_frame <= w_frame;
                r_match_cnt  <= w_match_next;
            end
            if (w_accept) begin
                case (r_state)
                    ST_IDLE, ST_MULTI: begin
                        if (w_keys == 2'd1) begin
                            r_state     <= ST_HELD;
                            r_key_held  <= 1'b1;
                            r_multi     <= 1'b0;
                            r_key_code  <= w_code;
                            r_key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            r_rep_cnt   <= '0;
`endif
                        end else if (w_keys == 2'd0) begin
                            r_state    <= ST_IDLE;
                            r_key_held <= 1'b0;
                            r_multi    <= 1'b0;
                        end else begin
                            r_state    <= ST_MULTI;
                            r_key_held <= 1'b0;
                            r_multi    <= 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (w_keys == 2'd0) begin
                            r_state    <= ST_IDLE;
                            r_key_held <= 1'b0;
                            r_multi    <= 1'b0;
                        end else if (w_keys == 2'd2) begin
                            r_state    <= ST_MULTI;
                            r_key_held <= 1'b0;
                            r_multi    <= 1'b1;
                        end else if (w_code != r_key_code) begin
                            r_key_code  <= w_code;
                            r_key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            r_rep_cnt   <= '0;
                        end else if (r_rep_cnt == REP_W'(REPEAT - 1)) begin
                            r_key_valid <= 1'b1;
                            r_rep_cnt   <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + REP_W'(1);
`endif
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_key_held <= 1'b0;
                        r_multi    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;
    assign o_multi     = r_multi;

endmodule

// File: tb/tb_keypad_reader.sv
// Directed plus randomized sweeps of keypad_reader, checked against a
// frame-level reference model (KEYPAD_REPEAT_EN selects the repeat model).
module tb_keypad_reader;

    localparam int SETTLE   = 3;
    localparam int DEBOUNCE = 4;
    localparam int REPEAT   = 8;
    localparam int HOLD     = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int double_cnt = 0;
    logic prev_valid = 1'b0;

    // Reference model state
    logic [15:0] m_hist[$];
    int m_state;   // 0 idle, 1 one key held, 2 several keys
    int m_code;
    int m_pulses;
`ifdef KEYPAD_REPEAT_EN
    int m_rep;
`endif

    keypad_reader #(
        .SETTLE   (SETTLE),
        .DEBOUNCE (DEBOUNCE)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT   (REPEAT)
`endif
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_col       (col),
        .i_row       (row),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_held  (key_held),
        .o_multi     (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            if (prev_valid === 1'b1) double_cnt++;
        end
        prev_valid = key_valid;
    end

    task automatic model_reset();
        m_hist.delete();
        m_state = 0;
        m_code  = 0;
`ifdef KEYPAD_REPEAT_EN
        m_rep   = 0;
`endif
    endtask

    task automatic model_accept(input logic [15:0] f);
        int n;
        int k;
        n = $countones(f);
        k = 0;
        for (int i = 0; i < 16; i++) if (f[i]) k = i;
        if (n == 0) begin
            m_state = 0;
        end else if (n >= 2) begin
            m_state = 2;
        end else begin
            if (m_state != 1 || k != m_code) begin
                m_pulses++;
                m_code = k;
`ifdef KEYPAD_REPEAT_EN
                m_rep = 0;
            end else begin
                m_rep++;
                if (m_rep == REPEAT) begin
                    m_pulses++;
                    m_rep = 0;
                end
`endif
            end
            m_state = 1;
        end
    endtask

    // A frame is accepted when the last DEBOUNCE complete frames are identical.
    task automatic model_frame(input logic [15:0] f);
        logic all_eq;
        m_hist.push_back(f);
        if (m_hist.size() > DEBOUNCE) m_hist.delete(0);
        if (m_hist.size() == DEBOUNCE) begin
            all_eq = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != f) all_eq = 1'b0;
            if (all_eq) model_accept(f);
        end
    endtask

    task automatic check(input string tag);
        n_cmp++;
        assert (pulse_cnt === m_pulses) else begin
            n_err++;
            $error("FAIL %s pulses: got %0d expected %0d", tag, pulse_cnt, m_pulses);
        end
        n_cmp++;
        assert (key_held === 1'(m_state == 1)) else begin
            n_err++;
            $error("FAIL %s key_held: got %b expected %b", tag, key_held, m_state == 1);
        end
        n_cmp++;
        assert (multi === 1'(m_state == 2)) else begin
            n_err++;
            $error("FAIL %s multi: got %b expected %b", tag, multi, m_state == 2);
        end
        n_cmp++;
        assert (key_code === 4'(m_code)) else begin
            n_err++;
            $error("FAIL %s key_code: got %0d expected %0d", tag, key_code, m_code);
        end
        $display("[%0t] %s: pulses=%0d held=%b multi=%b code=%0d", $time, tag,
                 pulse_cnt, key_held, multi, key_code);
    endtask

    task automatic drive_cols(input logic [15:0] f, input int first, input int last);
        for (int c = first; c <= last; c++) begin
            col = 4'(1 << c);
            row = f[4*c +: 4];
            repeat (HOLD) @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [15:0] f, input string tag);
        drive_cols(f, 0, 3);
        model_frame(f);
        check(tag);
    endtask

    task automatic kill_sweep();
        col = 4'b0000;
        row = 4'($urandom);
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        col   = 4'b0001;
        row   = 4'b0000;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] f;
        int sel;
        int len;
        int a;
        int b;

        rst_n = 1'b0;
        col = 4'b0000;
        row = 4'b0000;
        m_pulses = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("reset");

        for (int i = 0; i < 20; i++) run_frame(16'h0000, "idle_sweep");
        for (int i = 0; i < 6; i++) run_frame(16'h0040, "key6_hold");

        for (int i = 0; i < 4; i++) run_frame(16'h0000, "release");
        for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? 16'h0040 : 16'h0000, "bounce");
        for (int i = 0; i < 4; i++) run_frame(16'h0040, "settled");

        for (int i = 0; i < 4; i++) run_frame(16'h0240, "keys6_9");
        for (int i = 0; i < 4; i++) run_frame(16'h0040, "release9");

        for (int i = 0; i < 4; i++) run_frame(16'h0000, "release_all");
        run_frame(16'h0040, "pre_abort");
        run_frame(16'h0040, "pre_abort");
        drive_cols(16'h0040, 0, 1);
        kill_sweep();
        drive_cols(16'h0040, 2, 3);
        run_frame(16'h0040, "post_abort3");
        run_frame(16'h0040, "post_abort4");

        for (int i = 0; i < 4; i++) run_frame(16'h0000, "release_all");
        for (int i = 0; i < 30 + DEBOUNCE - 1; i++) run_frame(16'h8000, "key15_hold");

        drive_cols(16'h8000, 0, 1);
        do_reset();
        check("reset_midframe");
        run_frame(16'h0000, "after_reset");

        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: f = 16'h0000;
                1: f = 16'(1 << $urandom_range(0, 15));
                2: begin
                    a = $urandom_range(0, 15);
                    b = (a + 1 + $urandom_range(0, 14)) % 16;
                    f = 16'(1 << a) | 16'(1 << b);
                end
                default: f = 16'($urandom);
            endcase
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 9) == 0) begin
                    drive_cols(16'($urandom), 0, $urandom_range(0, 2));
                    kill_sweep();
                end
                run_frame(f, "random");
            end
        end

        n_cmp++;
        assert (double_cnt === 0) else begin
            n_err++;
            $error("FAIL back_to_back_valid: got %0d expected 0", double_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_reader.md
# keypad_reader

Receive side of the 4x4 keypad scan. The column sweep drives one-hot column strobes, and this block samples the returned row lines against those strobes. It assembles a 16-bit scan frame per sweep, debounces frames, and decodes a single pressed key into a 4-bit code with a one-cycle valid pulse. It sits between the board keypad pins and the control logic, alongside the column sweep.

## Interface
- SETTLE, 3: clocks a column strobe must be stable before rows are sampled.
- DEBOUNCE, 4: consecutive identical complete frames required before a frame is accepted (1..15).
- REPEAT, 64: accepted frames between auto-repeat pulses (only with `KEYPAD_REPEAT_EN`).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- col  in  4  column strobe from the sweep, one-hot, synchronous to clk.
- row  in  4  raw row lines, active-high, asynchronous.
- key_code  out  4  {column index, row index} of the held key.
- key_valid  out  1  one-cycle pulse: new key accepted (or repeat).
- key_held  out  1  level: a single key is currently accepted as pressed.
- multi  out  1  level: accepted frame has two or more keys set.

## Operation
- Row sync: `row` passes through a 2-flop synchronizer. Raw `row` is never used.
- Stability counter:
  - Resets to 0 on any clock where `col` differs from its previous value.
  - Otherwise increments, saturating at SETTLE+1.
- Sampling: when the counter equals SETTLE and `col` is one-hot, the synced rows are written into frame bits [4c+3:4c], where c is the index of the set `col` bit. Capture-mask bit c is set.
- Invalid column: if `col` is not one-hot (0000, or more than one bit set), nothing is sampled. The frame buffer and capture mask are cleared.
- Frame complete: a sample at c=3 with the capture mask equal to 1111 after that sample. The frame is then compared with the previous complete frame:
  - Equal: the match counter increments, saturating at DEBOUNCE.
  - Different: the match counter is set to 1.
  - In both cases the capture mask clears for the next frame.
- Acceptance: the frame is accepted when the match counter reaches DEBOUNCE. The accepted frame drives the key FSM.
- Key FSM states and transitions:
  - IDLE, on an accepted frame:
    - Zero keys set: stay in IDLE.
    - Exactly one key set: go to HELD, latch `key_code`, pulse `key_valid`.
    - Two or more keys set: go to MULTI.
  - HELD, on an accepted frame:
    - All zero: go to IDLE.
    - Same single key: stay in HELD.
    - A different single key: latch the new code and pulse `key_valid`.
    - Two or more keys: go to MULTI, keep `key_code`.
  - MULTI, on an accepted frame:
    - All zero: go to IDLE.
    - Exactly one key set: go to HELD, latch the code, pulse `key_valid`.
- Outputs: `key_held` is 1 only in HELD. `multi` is 1 only in MULTI.
- `key_code` keeps its last latched value in IDLE and MULTI.
- Code arithmetic: `key_code` = 4c + r, where r is the row bit index, giving range 0..15.

## Timing
- Reset values: `key_code`=0, `key_valid`=0, `key_held`=0, `multi`=0. FSM is in IDLE; frame buffer, capture mask and counters are all 0.
- Sample point: SETTLE clocks after a `col` change. With the 2-flop sync, rows must be valid by clock SETTLE-2 after the strobe. The sweep must hold each column at least SETTLE+1 clocks.
- Latency: `key_valid` asserts on the clock after the sampling edge of the column-3 sample that completes the accepting frame. Outputs update on that same edge.
- `key_valid` is never high for two consecutive clocks.
- Reset mid-frame: partial frame discarded. The FSM returns to IDLE with no pulse.
- Sweep stopped (`col` frozen): no new samples are taken and the FSM holds its state indefinitely.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a repeat counter increments on each accepted frame.
  - When it reaches REPEAT, `key_valid` pulses with the same `key_code` and the counter clears.
  - The counter clears on every transition into HELD.
- Not defined: no repeat counter is synthesized. A held key produces exactly one pulse.

## Structure
- Package `keypad_pkg`:
  - FSM state enum (IDLE, HELD, MULTI).
  - KEY_W=4 and FRAME_W=16 constants.
  - Function `onehot_idx` (4-bit one-hot to 2-bit index).
  - Function `popcnt16`, saturating at 2.
- Sub-module `keypad_frame_capture` contains:
  - the row synchronizer,
  - the stability counter,
  - the capture mask and frame buffer.
  - It emits `frame[15:0]` with a one-cycle `frame_done` strobe.
- Top level holds the debounce counter and key FSM.

## Test plan
- Reset with `col`=0001 sweeping, rows 0 -> all outputs 0 and no `key_valid` for 20 frames.
- Row 0100 asserted only while `col`=0010, held for 6 frames, DEBOUNCE=4 -> one `key_valid` after the 4th complete frame, `key_code`=6 (4·1+2), `key_held`=1.
- Same key with rows toggling every frame (bounce), then stable -> no pulse until 4 identical frames are seen.
- Keys 6 and 9 held together -> `multi`=1, `key_held`=0, no pulse. Release 9 -> pulse with `key_code`=6.
- `col` forced to 0000 mid-frame, then the sweep resumes -> partial frame discarded, debounce counts only full frames.
- With `KEYPAD_REPEAT_EN` and REPEAT=8, key 15 held 30 accepted frames -> initial pulse plus a pulse every 8 accepted frames, `key_code`=15 throughout.
